// File: rtl/apb_traffic_sequencer.sv
// Traffic-light sequencer: RED -> GREEN -> YELLOW cycling with per-phase timers,
// a prescaled tick, a blink mode for red or yellow, and a phase-entry pulse.
module apb_traffic_sequencer #(
  parameter int PRESCALE    = 4,
  parameter int BLINK_TICKS = 8
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [3:0]  ctl_i,
  input  logic [31:0] timer_0_i,
  input  logic [31:0] timer_1_i,
  output logic [1:0]  state_o,
  output logic        red_o,
  output logic        yellow_o,
  output logic        green_o,
  output logic        phase_irq_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  // Encodings of the cycling states double as their state_o codes.
  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_BLINK  = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   pre_cnt;
  logic [11:0]     phase_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_sel_red;

  logic            mod_en;
  logic            blink_red;
  logic            blink_any;
  logic [31:0]     timer_sel;
  logic            tick;
  logic [PW-1:0]   pre_next;
  logic            enter_phase;
  state_t          target;
  logic [11:0]     load_val;

  assign mod_en    = ctl_i[0];
  assign blink_red = ctl_i[2];
  assign blink_any = ctl_i[2] | ctl_i[1];
  assign timer_sel = ctl_i[3] ? timer_1_i : timer_0_i;
  assign tick      = (pre_cnt == PRE_MAX);
  assign pre_next  = tick ? '0 : pre_cnt + 1'b1;

  // Decide whether this edge starts a new normal phase and what it loads.
  always_comb begin
    enter_phase = 1'b0;
    target      = S_RED;
    load_val    = 12'd0;
    if (mod_en && !blink_any) begin
      case (state)
        S_OFF, S_BLINK: begin
          enter_phase = 1'b1;
          target      = S_RED;
        end
        S_RED: begin
          enter_phase = tick && (phase_cnt == 12'd0);
          target      = S_GREEN;
        end
        S_GREEN: begin
          enter_phase = tick && (phase_cnt == 12'd0);
          target      = S_YELLOW;
        end
        S_YELLOW: begin
          enter_phase = tick && (phase_cnt == 12'd0);
          target      = S_RED;
        end
        default: begin
          enter_phase = 1'b1;
          target      = S_RED;
        end
      endcase
    end
    case (target)
      S_RED:    load_val = timer_sel[19:8];
      S_GREEN:  load_val = timer_sel[31:20];
      S_YELLOW: load_val = {4'd0, timer_sel[7:0]};
      default:  load_val = 12'd0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= S_OFF;
      pre_cnt       <= '0;
      phase_cnt     <= 12'd0;
      blink_cnt     <= '0;
      blink_sel_red <= 1'b0;
      state_o       <= 2'b00;
      red_o         <= 1'b0;
      yellow_o      <= 1'b0;
      green_o       <= 1'b0;
      phase_irq_o   <= 1'b0;
    end else if (!mod_en) begin
      state         <= S_OFF;
      pre_cnt       <= '0;
      phase_cnt     <= 12'd0;
      blink_cnt     <= '0;
      blink_sel_red <= 1'b0;
      state_o       <= 2'b00;
      red_o         <= 1'b0;
      yellow_o      <= 1'b0;
      green_o       <= 1'b0;
      phase_irq_o   <= 1'b0;
    end else if (blink_any) begin
      state_o     <= 2'b00;
      green_o     <= 1'b0;
      phase_irq_o <= 1'b0;
      phase_cnt   <= 12'd0;
      // A fresh blink, or a switch of blinking lamp, restarts with the lamp on.
      if (state != S_BLINK || blink_sel_red != blink_red) begin
        state         <= S_BLINK;
        blink_sel_red <= blink_red;
        pre_cnt       <= '0;
        blink_cnt     <= '0;
        red_o         <= blink_red;
        yellow_o      <= ~blink_red;
      end else begin
        pre_cnt <= pre_next;
        if (tick) begin
          if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            if (blink_sel_red) red_o <= ~red_o;
            else               yellow_o <= ~yellow_o;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end else if (enter_phase) begin
      state       <= target;
      phase_cnt   <= load_val;
      pre_cnt     <= '0;
      blink_cnt   <= '0;
      phase_irq_o <= 1'b1;
      state_o     <= target[1:0];
      red_o       <= (target == S_RED);
      green_o     <= (target == S_GREEN);
      yellow_o    <= (target == S_YELLOW);
    end else begin
      phase_irq_o <= 1'b0;
      pre_cnt     <= pre_next;
      if (tick) phase_cnt <= phase_cnt - 12'd1;
    end
  end

endmodule

// File: doc/apb_traffic_sequencer.md
APB_TRAFFIC_SEQUENCER -- requirements
Module: apb_traffic_sequencer

Interface
REQ-001 Parameters SHALL be:
- PRESCALE, default 4: pclk cycles per tick; legal values are 1 and above.
- BLINK_TICKS, default 8: ticks per lamp toggle in blink mode; legal values are 1 and above.
REQ-002 Ports SHALL be:
- pclk  in  1  clock; all state changes on the rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- ctl_i  in  4  [3] profile, [2] blink_red, [1] blink_yellow, [0] mod_en.
- timer_0_i  in  32  profile 0: [31:20] g2y, [19:8] r2g, [7:0] y2r.
- timer_1_i  in  32  profile 1; same field layout as timer_0_i.
- state_o  out  2  00 OFF/BLINK, 01 RED, 10 GREEN, 11 YELLOW.
- red_o, yellow_o, green_o  out  1 each  lamp drives.
- phase_irq_o  out  1  one-cycle pulse on entry to RED, GREEN or YELLOW.
REQ-003 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Function
REQ-004 Internal FSM states SHALL be OFF, RED, GREEN, YELLOW, BLINK; state_o SHALL report 00 for both OFF and BLINK.
REQ-005 Mode priority each cycle SHALL be: mod_en=0 -> OFF; else blink_red=1 -> BLINK (red lamp); else blink_yellow=1 -> BLINK (yellow lamp); else normal cycling.
REQ-006 Timer word selection: ctl_i[3]=0 selects timer_0_i and ctl_i[3]=1 selects timer_1_i; the selected fields SHALL be sampled only at phase entry, so mid-phase changes to timers or profile take effect at the next phase.
REQ-007 Tick generator: prescale counter 0..PRESCALE-1, tick asserted when it equals PRESCALE-1; the counter SHALL reset to 0 on every phase entry and while in OFF.
REQ-008 Phase counter width SHALL be 12 bits; y2r SHALL be zero-extended on load.
REQ-009 On entry, RED SHALL load r2g, GREEN load g2y, YELLOW load y2r.
REQ-010 On each tick, if the phase counter is 0 the FSM SHALL advance, else the counter SHALL decrement.
REQ-011 Normal order SHALL be RED -> GREEN -> YELLOW -> RED; each phase SHALL last exactly (field+1)*PRESCALE cycles, and a field value of 0 SHALL give PRESCALE cycles.
REQ-012 mod_en sampled 1 at edge k from OFF, with no blink bit set, SHALL enter RED at edge k (state_o=01 from cycle k+1).
REQ-013 mod_en sampled 0 at any edge SHALL enter OFF at that edge, clear all lamps, and clear all counters.
REQ-014 A blink bit sampled 1 in RED, GREEN or YELLOW SHALL enter BLINK at that edge, abandoning the current phase count.
REQ-015 BLINK behaviour:
- The selected lamp SHALL be on in the first BLINK cycle and toggle every BLINK_TICKS ticks.
- The other lamps SHALL be off.
- A change between blink_red and blink_yellow SHALL restart BLINK with the new lamp on.
REQ-016 When the blink bits clear with mod_en=1, the FSM SHALL enter RED at that edge.
REQ-017 Lamps in RED, GREEN and YELLOW SHALL be one-hot, matching the state; all lamps SHALL be 0 in OFF.
REQ-018 phase_irq_o SHALL be 1 for exactly the first cycle of each RED, GREEN or YELLOW phase, including RED entered from OFF or BLINK; it SHALL never assert in OFF or BLINK.
REQ-019 Simultaneous events: a mode change SHALL take priority over a phase expiry occurring on the same edge.

Reset
REQ-020 presetn=0 SHALL asynchronously force: FSM=OFF, state_o=00, all lamps 0, phase_irq_o=0, all counters 0.
REQ-021 After presetn deasserts, the first edge with mod_en=1 SHALL behave per REQ-012; a reset asserted mid-phase SHALL discard all progress.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Cycling, PRESCALE=1, timer_0_i=32'h0030_0205, ctl_i=4'b0001: RED 3 cycles, GREEN 4, YELLOW 6, repeating; phase_irq_o pulses at each entry.
- Prescale, PRESCALE=4, same word: RED 12 cycles, GREEN 16, YELLOW 24.
- Zero fields, timer_1_i=0 with profile=1: each phase lasts PRESCALE cycles.
- Profile switch mid-GREEN: the current GREEN completes with the old g2y; the next YELLOW uses timer_1_i y2r.
- Blink: blink_yellow=1 mid-GREEN -> next cycle state_o=00, yellow_o=1, toggling every BLINK_TICKS*PRESCALE cycles; then blink_red=1 -> red lamp restarts on; clearing both -> RED with a phase_irq_o pulse.
- Reset: presetn low mid-YELLOW -> immediately all outputs 0, independent of pclk; mod_en=0 mid-RED -> OFF at the next edge with lamps off.
